tlut_accum: RTL and testbench
=============================

// Module: tlut_accum
// PURPOSE
//  Sequencer and accumulator paired with the temporal comparator stage.
//  - Drives the comparator's rng ramp and enable across one window of 2**INPUT_WIDTH cycles.
//  - Consumes the comparator's registered per-lane bitstream (1-cycle latency).
//  - Each cycle a lane bit is 1, adds the latched B operand into that lane's accumulator.
//  - At window end, acc[i] = A[i]*B. Results are presented through a valid/ready output handshake.
// PARAMETERS
//  DIM_A         8    number of lanes; must match the comparator DIM_A
//  INPUT_WIDTH   8    rng / A-operand width; window length = 2**INPUT_WIDTH cycles
//  WEIGHT_WIDTH  8    width of the shared B operand
//  ACC_WIDTH     INPUT_WIDTH+WEIGHT_WIDTH   per-lane accumulator width; holds the exact product
// PORTS
//  clk        in   1                  clock, rising edge
//  rst_n      in   1                  reset, asynchronous, active-low
//  start      in   1                  start request; accepted only when in_ready=1
//  weight     in   WEIGHT_WIDTH       B operand, sampled on the accepted start
//  in_ready   out  1                  1 when state==IDLE (combinational from state)
//  rng        out  INPUT_WIDTH        ramp to comparator rng input (registered)
//  cmp_en     out  1                  enable to comparator (registered)
//  bit_in     in   DIM_A              comparator cmp_out bitstream
//  out_valid  out  1                  result valid (registered)
//  out_ready  in   1                  downstream accepts result
//  acc_out    out  DIM_A*ACC_WIDTH    per-lane products; lane i at [i*ACC_WIDTH +: ACC_WIDTH]
// BEHAVIOUR
//  Reset values:
//  - state=IDLE; rng=0; cmp_en=0; out_valid=0; all acc=0; weight_q=0; acc_en=0; in_ready=1.
//  FSM states: IDLE, RUN, DRAIN, DONE.
//  - IDLE: on start, latch weight_q=weight, clear all acc, set rng=0, cmp_en=1, go to RUN.
//  - RUN: rng increments by 1 each cycle (0..2**INPUT_WIDTH-1).
//    - In the cycle rng==max: next rng=0, cmp_en=0, go to DRAIN.
//    - RUN lasts exactly 2**INPUT_WIDTH cycles.
//  - DRAIN: one cycle, so the last comparator result (rng=max) is accumulated; then go to DONE.
//  - DONE: out_valid=1 and acc_out is held stable.
//    - On out_valid&&out_ready: out_valid=0 and go to IDLE.
//    - acc is not cleared until the next start.
//  Accumulation:
//  - acc_en is cmp_en delayed one register, aligning with the comparator latency.
//  - Each cycle acc_en=1: acc[i] += bit_in[i] ? weight_q : 0, for every lane in parallel.
//  - The sum is zero-extended to ACC_WIDTH. Overflow is impossible, since max=(2**IW-1)*(2**WW-1).
//  Timing (start accepted at edge ending cycle 0):
//  - RUN occupies cycles 1..2**IW, DRAIN is cycle 2**IW+1, out_valid rises at cycle 2**IW+2.
//  - Latency start->out_valid = 2**IW+2 cycles.
//  Boundary conditions:
//  - start while state!=IDLE: ignored, with no effect on rng, acc or weight_q.
//  - start in the same cycle as the DONE handshake: ignored; in_ready rises the following cycle.
//  - weight changes after start: no effect; weight_q is used for the whole window.
//  - bit_in with acc_en=0: ignored.
//  - out_ready low: DONE holds indefinitely with acc_out stable.
//  - rng wrap: the max->0 transition happens only at the RUN->DRAIN exit; rng is 0 outside RUN.
//  - rst_n asserted mid-window: immediate return to reset values.
//    - The comparator shares rst_n, so no stale bits are accumulated after release.
// TESTING
//  1. A={0,1,2,3,127,128,254,255}, weight=3, out_ready=1 -> acc_out={0,3,6,9,381,384,762,765}.
//     out_valid is asserted exactly at cycle 258 after start (single cycle).
//  2. All A=255, weight=255 -> every lane 65025 (0xFE01), with no overflow.
//  3. A=100, weight=7, change weight to 50 at cycle 10 and pulse start in RUN -> result 700.
//     rng still completes 0..255 once.
//  4. out_ready=0 for 20 cycles in DONE -> out_valid and acc_out are stable.
//     Handshake with start high in the same cycle -> IDLE, no new window.
//     start next cycle -> new window.
//  5. Assert rst_n=0 at cycle 120 of RUN -> all outputs at reset values.
//     Then start A=5, weight=9 -> 45 on all lanes, no residue.
//  6. Back-to-back: two windows with weight 1 then 2, same A=200 -> results 200 then 400.
//     Accumulator cleared at the second start.

Source files
------------

// File: rtl/tlut_accum.sv
// Temporal-LUT sequencer/accumulator: ramps the comparator rng over one window and
// sums the shared weight into each lane whose bitstream is high, giving A[i]*B per lane.
module tlut_accum #(
  parameter int DIM_A        = 8,
  parameter int INPUT_WIDTH  = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = INPUT_WIDTH + WEIGHT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [WEIGHT_WIDTH-1:0]    weight,
  output logic                       in_ready,
  output logic [INPUT_WIDTH-1:0]     rng,
  output logic                       cmp_en,
  input  logic [DIM_A-1:0]           bit_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DIM_A*ACC_WIDTH-1:0] acc_out
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                  r_state;
  logic [INPUT_WIDTH-1:0]  r_rng;
  logic                    r_cmp_en;
  logic                    r_acc_en;
  logic                    r_out_valid;
  logic [WEIGHT_WIDTH-1:0] r_weight_q;
  logic [ACC_WIDTH-1:0]    r_acc [DIM_A];

  assign in_ready  = (r_state == S_IDLE);
  assign rng       = r_rng;
  assign cmp_en    = r_cmp_en;
  assign out_valid = r_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rng       <= '0;
      r_cmp_en    <= 1'b0;
      r_acc_en    <= 1'b0;
      r_out_valid <= 1'b0;
      r_weight_q  <= '0;
      for (int unsigned i = 0; i < DIM_A; i++) r_acc[i] <= '0;
    end else begin
      // acc_en trails cmp_en by the comparator's one-register latency
      r_acc_en <= r_cmp_en;
      if (r_acc_en) begin
        for (int unsigned i = 0; i < DIM_A; i++)
          if (bit_in[i]) r_acc[i] <= r_acc[i] + ACC_WIDTH'(r_weight_q);
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_weight_q <= weight;
            for (int unsigned i = 0; i < DIM_A; i++) r_acc[i] <= '0;
            r_rng    <= '0;
            r_cmp_en <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_rng == '1) begin
            r_rng    <= '0;
            r_cmp_en <= 1'b0;
            r_state  <= S_DRAIN;
          end else begin
            r_rng <= r_rng + INPUT_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    acc_out = '0;
    for (int unsigned i = 0; i < DIM_A; i++)
      acc_out[i*ACC_WIDTH +: ACC_WIDTH] = r_acc[i];
  end

endmodule

// File: tb/tb_tlut_accum.sv
// Bench for tlut_accum: models the registered comparator, runs table-driven windows and
// hand-written sequences for hold, ignored start, weight change and mid-window reset.
module tb_tlut_accum;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [7:0]   weight;
  logic         in_ready;
  logic [7:0]   rng;
  logic         cmp_en;
  logic [7:0]   bit_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] acc_out;

  logic [63:0]  a_ops;
  int           n_checks;
  int           n_fail;

  tlut_accum #(
    .DIM_A(8),
    .INPUT_WIDTH(8),
    .WEIGHT_WIDTH(8),
    .ACC_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .weight(weight),
    .in_ready(in_ready),
    .rng(rng),
    .cmp_en(cmp_en),
    .bit_in(bit_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .acc_out(acc_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Comparator model: one registered bit per lane, high while rng < A[i]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bit_in <= '0;
    else begin
      for (int i = 0; i < 8; i++)
        bit_in[i] <= cmp_en && (rng < a_ops[i*8 +: 8]);
    end
  end

  typedef struct {
    logic [63:0]  a;
    logic [7:0]   w;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 of the new window
  task automatic start_window(input logic [63:0] a, input logic [7:0] w);
    a_ops  = a;
    weight = w;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("c1_in_ready", in_ready, 0);
    chk("c1_rng", rng, 0);
    chk("c1_cmp_en", cmp_en, 1);
    chk("c1_acc_cleared", acc_out, 0);
  endtask

  // Walks the window from cycle 1 checking the ramp; returns at the out_valid cycle
  task automatic wait_done();
    int c;
    int rerr;
    int lat;
    int exp_rng;
    c = 1; rerr = 0; lat = 0;
    while (c < 400) begin
      if (out_valid) begin
        lat = c;
        break;
      end
      exp_rng = (c <= 256) ? c - 1 : 0;
      if (rng !== exp_rng[7:0] || cmp_en !== (c <= 256)) rerr++;
      @(negedge clk);
      c++;
    end
    chk("rng_ramp_errors", rerr, 0);
    chk("latency", lat, 258);
  endtask

  task automatic finish_handshake();
    @(negedge clk);
    chk("valid_single_cycle", out_valid, 0);
    chk("in_ready_after", in_ready, 1);
  endtask

  task automatic run_check(input logic [63:0] a, input logic [7:0] w, input logic [127:0] exp);
    start_window(a, w);
    wait_done();
    chk("acc_out", acc_out, exp);
    finish_handshake();
  endtask

  initial begin
    logic [127:0] held;
    int unstable;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    weight   = '0;
    out_ready = 1'b1;
    a_ops    = '0;

    vecs[0] = '{a: 64'hFFFE_807F_0302_0100, w: 8'd3,
                exp: 128'h02FD_02FA_0180_017D_0009_0006_0003_0000};
    vecs[1] = '{a: {8{8'hFF}}, w: 8'hFF, exp: {8{16'hFE01}}};
    vecs[2] = '{a: {8{8'h55}}, w: 8'd0,  exp: '0};
    vecs[3] = '{a: {8{8'hC8}}, w: 8'd1,  exp: {8{16'h00C8}}};
    vecs[4] = '{a: {8{8'hC8}}, w: 8'd2,  exp: {8{16'h0190}}};
    vecs[5] = '{a: 64'h0807_0605_0403_0201, w: 8'd10,
                exp: 128'h0050_0046_003C_0032_0028_001E_0014_000A};

    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_rng", rng, 0);
    chk("rst_cmp_en", cmp_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc", acc_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back windows; entries 3 and 4 prove the clear at start
    for (int v = 0; v < 6; v++)
      run_check(vecs[v].a, vecs[v].w, vecs[v].exp);

    // Weight change and a stray start during RUN must not disturb the window
    start_window({8{8'd100}}, 8'd7);
    fork
      wait_done();
      begin
        repeat (9) @(negedge clk);
        weight = 8'd50;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
      end
    join
    chk("weight_change_acc", acc_out, {8{16'd700}});
    finish_handshake();

    // DONE held with out_ready low, then handshake with start high
    out_ready = 1'b0;
    start_window({8{8'd16}}, 8'd10);
    wait_done();
    held = acc_out;
    chk("hold_acc", held, {8{16'd160}});
    unstable = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || acc_out !== held || in_ready !== 1'b0) unstable++;
    end
    chk("hold_stable_errors", unstable, 0);
    out_ready = 1'b1;
    weight    = 8'd3;
    start     = 1'b1;
    @(negedge clk);
    chk("hs_start_ignored_ready", in_ready, 1);
    chk("hs_start_ignored_en", cmp_en, 0);
    chk("hs_valid_low", out_valid, 0);
    chk("hs_acc_kept", acc_out, held);
    start_window({8{8'd16}}, 8'd3);
    wait_done();
    chk("after_hs_acc", acc_out, {8{16'd48}});
    finish_handshake();

    // Reset mid-window, then a clean window with no residue
    start_window({8{8'd200}}, 8'd77);
    repeat (119) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_rng", rng, 0);
    chk("midrst_cmp_en", cmp_en, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_acc", acc_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_check({8{8'd5}}, 8'd9, {8{16'd45}});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
